regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined CPU datapath: configurable data width and depth, two combinational read ports, one write port.
- Adds what the previous fixed 32x32 file lacks:
  - asynchronous reset;
  - a hardwired zero register;
  - optional write-to-read bypass;
  - a per-register pending-write scoreboard that the decode stage uses for hazard stalls.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, register address width
- NUM_REGS, 2**ADDR_W, number of registers
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and is never pending
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports
- CNT_W, 2, width of each per-register pending-write counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr1  in  ADDR_W  read address, port 1
- raddr2  in  ADDR_W  read address, port 2
- rdata1  out  DATA_W  read data, port 1 (combinational)
- rdata2  out  DATA_W  read data, port 2 (combinational)
- pend1  out  1  register at raddr1 has an outstanding write not satisfied this cycle
- pend2  out  1  same for raddr2
- issue_valid  in  1  decode issues an instruction that will write issue_rd
- issue_rd  in  ADDR_W  destination of the issued instruction
- issue_ready  out  1  issue can be accepted (counter for issue_rd not saturated)
- err_underflow  out  1  sticky: a write arrived for a register with zero pending count

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - While rst_n=0: all registers = 0, all counters = 0, err_underflow = 0.
  - Consequently rdata1/2 = 0, pend1/2 = 0, issue_ready = 1.
  - Reset asserted mid-operation discards all pending state immediately, without waiting for a clock edge.
- Write:
  - On the rising edge, if we=1, regs[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - Out-of-range waddr (>= NUM_REGS) is dropped.
- Read:
  - Zero latency; rdataN = regs[raddrN].
  - If BYPASS=1, we=1, waddr=raddrN and the write is not dropped, then rdataN = wdata.
  - If ZERO_REG=1 and raddrN=0, rdataN = 0 always.
  - Out-of-range raddr returns 0.
- Scoreboard:
  - One CNT_W counter per register.
  - An issue is accepted when issue_valid=1 and issue_ready=1.
  - An accepted issue increments cnt[issue_rd]; a non-dropped write decrements cnt[waddr].
  - Issue and write to the same register in the same cycle leave the count unchanged.
  - Issue and write to different registers update both counters independently.
  - issue_ready = (cnt[issue_rd] != 2**CNT_W-1); it is 1 for register 0 when ZERO_REG=1.
  - An issue to register 0 with ZERO_REG=1 is accepted with no count change.
  - Write to a register with cnt=0:
    - data is written;
    - the counter stays 0 (no wrap);
    - err_underflow is set and stays 1 until reset.
  - The underflow case does not apply when that cycle also accepts an issue to the same register; the net count is then unchanged.
- Pending flags:
  - pendN = (cnt[raddrN] != 0) and not satisfied this cycle.
  - The flag is satisfied this cycle when BYPASS=1, we=1, waddr=raddrN and cnt[raddrN]=1 (the last outstanding write is being forwarded).
  - With BYPASS=0, pendN = (cnt[raddrN] != 0).
  - pendN = 0 for register 0 when ZERO_REG=1.
- Maximum in-flight writes per register: 2**CNT_W-1.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W / ADDR_W / CNT_W constants;
  - a function returning the counter saturation value;
  - a function for the "address is zero register" test.
- One natural sub-module: regfile_scoreboard.
  - Contains the counter bank, issue_ready, pend flags and err_underflow.
  - Parametrised by ADDR_W, NUM_REGS, CNT_W, ZERO_REG, BYPASS.
- The storage array, write logic and bypass muxes remain in regfile_sb.

Test Plan:
- Reset: hold rst_n=0 after writing regs 5 with 0xDEADBEEF, then release -> rdata1(raddr1=5)=0, pend1=0, issue_ready=1, err_underflow=0.
- Zero register: we=1, waddr=0, wdata=0x1234 -> next cycle rdata1(raddr1=0)=0. Issue to rd 0 -> pend1=0 and issue_ready=1.
- Bypass: we=1, waddr=7, wdata=0xA5A5A5A5 with raddr2=7 in the same cycle -> rdata2=0xA5A5A5A5 before the edge. With BYPASS=0 -> old value 0.
- Scoreboard saturation (CNT_W=2): issue rd 3 three times -> pend1(raddr1=3)=1, issue_ready=0 for rd 3, fourth issue not counted. Three writes to 3 -> cnt 0, pend1=0.
- Simultaneous issue+write to rd 9 with cnt=1 -> cnt stays 1, pend stays 1, err_underflow=0. Write to rd 10 with cnt=0 -> data written, err_underflow=1 and sticky until reset.
- Async reset mid-operation: cnt[4]=2, drop rst_n between clock edges -> pend, regs and err_underflow clear immediately without a clk edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W  = 2;

    // Largest value a pending-write counter can hold before issues must stall.
    function automatic int unsigned cnt_sat(input int unsigned cnt_w);
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    function automatic logic is_zero_reg(input int unsigned addr, input bit zero_reg);
        return zero_reg && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters used by decode for hazard stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = 2**ADDR_W,
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_commit,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic              pend1,
    output logic              pend2,
    output logic              err_underflow
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(cnt_sat(CNT_W));

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [CNT_W-1:0]    cnt_issue;
    logic [CNT_W-1:0]    cnt_r1;
    logic [CNT_W-1:0]    cnt_r2;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                issue_zero;
    logic                issue_acc;
    logic                underflow;

    always_comb begin
        cnt_issue = '0;
        cnt_r1    = '0;
        cnt_r2    = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (issue_rd == ADDR_W'(i)) cnt_issue = cnt[i];
            if (raddr1 == ADDR_W'(i))   cnt_r1    = cnt[i];
            if (raddr2 == ADDR_W'(i))   cnt_r2    = cnt[i];
        end
        issue_zero  = is_zero_reg(32'(issue_rd), ZERO_REG);
        issue_ready = issue_zero || (cnt_issue != SAT);
        // Zero-register issues are accepted but never counted.
        issue_acc   = issue_valid && issue_ready && !issue_zero;
        pend1 = (cnt_r1 != '0) &&
                !(BYPASS && wr_commit && (waddr == raddr1) && (cnt_r1 == CNT_W'(1)));
        pend2 = (cnt_r2 != '0) &&
                !(BYPASS && wr_commit && (waddr == raddr2) && (cnt_r2 == CNT_W'(1)));
    end

    always_comb begin
        inc       = '0;
        dec       = '0;
        underflow = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            inc[i] = issue_acc && (issue_rd == ADDR_W'(i));
            dec[i] = wr_commit && (waddr == ADDR_W'(i));
            underflow = underflow | (dec[i] && !inc[i] && (cnt[i] == '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (inc[i] && !dec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (dec[i] && !inc[i] && (cnt[i] != '0))
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
            if (underflow) err_underflow <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised 2R/1W register file with zero register, write bypass and
// pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = 2**ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              pend1,
    output logic              pend2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    output logic              issue_ready,
    output logic              err_underflow
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;

    // A write commits only when it targets a real, writable register.
    always_comb begin
        wr_commit = we && (32'(waddr) < NUM_REGS) && !is_zero_reg(32'(waddr), ZERO_REG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                if (waddr == ADDR_W'(i)) regs[i] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (raddr1 == ADDR_W'(i)) rdata1 = regs[i];
            if (raddr2 == ADDR_W'(i)) rdata2 = regs[i];
        end
        if (BYPASS && wr_commit && (waddr == raddr1)) rdata1 = wdata;
        if (BYPASS && wr_commit && (waddr == raddr2)) rdata2 = wdata;
        if (is_zero_reg(32'(raddr1), ZERO_REG)) rdata1 = '0;
        if (is_zero_reg(32'(raddr2), ZERO_REG)) rdata2 = '0;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_commit     (wr_commit),
        .waddr         (waddr),
        .raddr1        (raddr1),
        .raddr2        (raddr2),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .issue_ready   (issue_ready),
        .pend1         (pend1),
        .pend2         (pend2),
        .err_underflow (err_underflow)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, async-reset sequence and random
// traffic against an array/integer reference model (BYPASS=1 and BYPASS=0 copies).
module tb_regfile_sb;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [AW-1:0] raddr1 = '0;
    logic [AW-1:0] raddr2 = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;

    logic [DW-1:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
    logic          pend1, pend2, issue_ready, err_underflow;
    logic          nb_pend1, nb_pend2, nb_issue_ready, nb_err_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] mregs [NR];
    int            mcnt  [NR];
    bit            merr;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1'b1),
                 .BYPASS(1'b1), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .pend1(pend1), .pend2(pend2), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .err_underflow(err_underflow));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .ZERO_REG(1'b1),
                 .BYPASS(1'b0), .CNT_W(2)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
        .pend1(nb_pend1), .pend2(nb_pend2), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(nb_issue_ready), .err_underflow(nb_err_underflow));

    typedef struct {
        bit we; int wa; logic [DW-1:0] wd; int ra1; int ra2; bit iv; int ird;
        logic [DW-1:0] e_rd1; logic [DW-1:0] e_rd2; bit e_p1; bit e_p2; bit e_rdy; bit e_err;
    } vec_t;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_rdata(input bit bp, input int ra);
        if (ra == 0) return '0;
        if (bp && we && waddr != 0 && int'(waddr) == ra) return wdata;
        return mregs[ra];
    endfunction

    function automatic bit m_pend(input bit bp, input int ra);
        if (ra == 0 || mcnt[ra] == 0) return 1'b0;
        if (bp && we && int'(waddr) == ra && mcnt[ra] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_ready();
        return (issue_rd == 0) || (mcnt[issue_rd] < 3);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NR; i++) begin
            mregs[i] = '0;
            mcnt[i]  = 0;
        end
        merr = 1'b0;
    endtask

    task automatic drive(input bit w, input int wa, input logic [DW-1:0] wd,
                         input int r1, input int r2, input bit iv, input int ir);
        we = w; waddr = AW'(wa); wdata = wd;
        raddr1 = AW'(r1); raddr2 = AW'(r2);
        issue_valid = iv; issue_rd = AW'(ir);
    endtask

    task automatic model_check();
        check("rdata1", rdata1, m_rdata(1'b1, int'(raddr1)));
        check("rdata2", rdata2, m_rdata(1'b1, int'(raddr2)));
        check("nb_rdata1", nb_rdata1, m_rdata(1'b0, int'(raddr1)));
        check("nb_rdata2", nb_rdata2, m_rdata(1'b0, int'(raddr2)));
        check("pend1", pend1, m_pend(1'b1, int'(raddr1)));
        check("pend2", pend2, m_pend(1'b1, int'(raddr2)));
        check("nb_pend1", nb_pend1, m_pend(1'b0, int'(raddr1)));
        check("nb_pend2", nb_pend2, m_pend(1'b0, int'(raddr2)));
        check("issue_ready", issue_ready, m_ready());
        check("nb_issue_ready", nb_issue_ready, m_ready());
        check("err_underflow", err_underflow, merr);
        check("nb_err_underflow", nb_err_underflow, merr);
    endtask

    // Apply the clock edge to both the DUTs and the model, return at the next negedge.
    task automatic clock_edge();
        bit acc, wr;
        int ir, wa;
        logic [DW-1:0] wd;
        acc = issue_valid && m_ready() && issue_rd != 0;
        wr  = we && waddr != 0;
        ir = int'(issue_rd); wa = int'(waddr); wd = wdata;
        @(posedge clk);
        if (wr) mregs[wa] = wd;
        if (!(acc && wr && ir == wa)) begin
            if (acc) mcnt[ir]++;
            if (wr) begin
                if (mcnt[wa] == 0) merr = 1'b1;
                else mcnt[wa]--;
            end
        end
        @(negedge clk);
    endtask

    task automatic cycle(input bit w, input int wa, input logic [DW-1:0] wd,
                         input int r1, input int r2, input bit iv, input int ir);
        drive(w, wa, wd, r1, r2, iv, ir);
        #2;
        model_check();
        clock_edge();
    endtask

    vec_t tbl[$];

    initial begin
        // we wa wd  ra1 ra2 iv ird | rd1 rd2 p1 p2 rdy err
        tbl.push_back('{1, 0, 32'h1234,     0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        32'h0,        0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        7, 0, 1, 7, 32'h0,        32'h0,        0, 0, 1, 0});
        tbl.push_back('{1, 7, 32'hA5A5A5A5, 7, 7, 0, 3, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        3, 7, 1, 3, 32'h0,        32'hA5A5A5A5, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        3, 7, 1, 3, 32'h0,        32'hA5A5A5A5, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        3, 7, 1, 3, 32'h0,        32'hA5A5A5A5, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        3, 7, 1, 3, 32'h0,        32'hA5A5A5A5, 1, 0, 0, 0});
        tbl.push_back('{1, 3, 32'h11,       3, 7, 0, 3, 32'h11,       32'hA5A5A5A5, 1, 0, 0, 0});
        tbl.push_back('{1, 3, 32'h22,       3, 7, 0, 3, 32'h22,       32'hA5A5A5A5, 1, 0, 1, 0});
        tbl.push_back('{1, 3, 32'h33,       3, 7, 0, 3, 32'h33,       32'hA5A5A5A5, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        3, 7, 0, 3, 32'h33,       32'hA5A5A5A5, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        9, 3, 1, 9, 32'h0,        32'h33,       0, 0, 1, 0});
        tbl.push_back('{1, 9, 32'h99,       9, 3, 1, 9, 32'h99,       32'h33,       0, 0, 1, 0});
        tbl.push_back('{0, 0, 32'h0,        9, 3, 0, 9, 32'h99,       32'h33,       1, 0, 1, 0});
        tbl.push_back('{1, 10, 32'hAA,     10, 9, 0, 9, 32'hAA,       32'h99,       0, 1, 1, 0});
        tbl.push_back('{0, 0, 32'h0,       10, 9, 0, 9, 32'hAA,       32'h99,       0, 1, 1, 1});

        m_reset();
        drive(1'b0, 0, '0, 5, 0, 1'b0, 5);
        #2;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_ready", issue_ready, 1'b1);
        model_check();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].ra1, tbl[k].ra2, tbl[k].iv, tbl[k].ird);
            #2;
            check($sformatf("vec%0d_rdata1", k), rdata1, tbl[k].e_rd1);
            check($sformatf("vec%0d_rdata2", k), rdata2, tbl[k].e_rd2);
            check($sformatf("vec%0d_pend1", k), pend1, tbl[k].e_p1);
            check($sformatf("vec%0d_pend2", k), pend2, tbl[k].e_p2);
            check($sformatf("vec%0d_ready", k), issue_ready, tbl[k].e_rdy);
            check($sformatf("vec%0d_err", k), err_underflow, tbl[k].e_err);
            model_check();
            clock_edge();
        end

        // Asynchronous reset between clock edges with outstanding state.
        cycle(1'b0, 0, '0, 4, 4, 1'b1, 4);
        cycle(1'b0, 0, '0, 4, 4, 1'b1, 4);
        cycle(1'b1, 5, 32'hDEADBEEF, 5, 4, 1'b0, 4);
        drive(1'b0, 0, '0, 5, 4, 1'b0, 4);
        #2;
        check("pre_rst_rdata1", rdata1, 32'hDEADBEEF);
        check("pre_rst_pend2", pend2, 1'b1);
        check("pre_rst_err", err_underflow, 1'b1);
        rst_n = 1'b0;
        #1;
        m_reset();
        check("async_rst_rdata1", rdata1, 32'h0);
        check("async_rst_pend2", pend2, 1'b0);
        check("async_rst_err", err_underflow, 1'b0);
        check("async_rst_ready", issue_ready, 1'b1);
        model_check();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("post_rst_rdata1", rdata1, 32'h0);
        check("post_rst_pend2", pend2, 1'b0);
        model_check();
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst_n = 1'b0;
                #1;
                m_reset();
                model_check();
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), DW'($urandom),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
